// File: rtl/addr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// addr_sequencer_pkg
// Shared definitions for the pattern-ROM address sequencer:
//   - seq_state_t : FSM state encoding (IDLE / RUN / PAUSE)
//   - ADDR_W_DEF  : default address/bounds width
//   - SEG_LEN     : entries per segment produced by the upstream selector
//   - TICK_W      : width of the step-rate counter (covers TICK_DIV up to 255)
// ---------------------------------------------------------------------------
package addr_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } seq_state_t;

    localparam int ADDR_W_DEF = 8;
    localparam int SEG_LEN    = 30;
    localparam int TICK_W     = 8;

endpackage

// File: rtl/addr_sequencer_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Step-rate counter for the address sequencer. Counts enabled cycles and
// wraps after TICK_DIV of them; step is high during the enabled cycle in
// which the count sits at its last value, so the consumer's registered
// address advances on the same edge the counter wraps.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset (count -> 0)
//   clr   in   synchronous clear (count -> 0), wins over en
//   en    in   count this cycle; when low the count is frozen
//   step  out  high in the enabled cycle that ends a TICK_DIV period
// ---------------------------------------------------------------------------
module tick_divider
    import addr_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] count_r;
    logic              wrap_s;

    assign wrap_s = (count_r == LAST);
    // Combinational on purpose: it qualifies the sequencer's next-address
    // logic for the very edge on which the count returns to zero.
    assign step   = en & wrap_s;

    // Tick counter: reset/clear to zero, count when enabled, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {TICK_W{1'b0}};
        end else if (clr) begin
            count_r <= {TICK_W{1'b0}};
        end else if (en) begin
            if (wrap_s) begin
                count_r <= {TICK_W{1'b0}};
            end else begin
                count_r <= count_r + {{(TICK_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/addr_sequencer.sv
// ---------------------------------------------------------------------------
// addr_sequencer
// Latches a segment's [addr_start..addr_finish] bounds on start and steps a
// ROM read address through them, one address every TICK_DIV cycles.
// One-shot or loop playback (loop sampled with start), level pause, abort.
// Ports:
//   clk, rst     clock (rising edge) / synchronous active-high reset
//   addr_start   first address of the selected segment
//   addr_finish  last address of the selected segment
//   start        one-cycle playback request (honoured only in IDLE)
//   loop         1 = wrap to start after finish, 0 = one-shot
//   pause        level; freezes tick count and address while high
//   abort        one-cycle; return to IDLE with a done pulse
//   addr         current ROM read address
//   addr_valid   high in RUN or PAUSE
//   busy         high in any state other than IDLE
//   done         one-cycle pulse at one-shot end or on abort
//   err          one-cycle pulse when start sees addr_start > addr_finish
// All outputs are registered.
// ---------------------------------------------------------------------------
module addr_sequencer
    import addr_sequencer_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int TICK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_start,
    input  logic [ADDR_W-1:0] addr_finish,
    input  logic              start,
    input  logic              loop,
    input  logic              pause,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    seq_state_t        state_r;
    seq_state_t        next_state_s;

    logic [ADDR_W-1:0] lo_r;
    logic [ADDR_W-1:0] hi_r;
    logic              lp_r;
    logic [ADDR_W-1:0] addr_r;
    logic              valid_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic [ADDR_W-1:0] addr_nxt_s;
    logic              done_nxt_s;
    logic              err_nxt_s;
    logic              latch_s;

    logic              bounds_ok_s;
    logic              active_s;
    logic              clr_s;
    logic              step_s;
    logic              at_end_s;

    assign bounds_ok_s = (addr_start <= addr_finish);
    assign at_end_s    = (addr_r == hi_r);
    assign clr_s       = (state_r == IDLE);
    // A cycle counts toward the step period whenever playback is live and
    // pause is low. This includes the PAUSE cycle in which pause drops, so
    // the remaining tick count resumes immediately on release.
    assign active_s    = ((state_r == RUN) || (state_r == PAUSE)) && !abort && !pause;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .en   (active_s),
        .step (step_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; priority abort > pause > tick advance.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && bounds_ok_s) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN, PAUSE: begin
                if (abort) begin
                    next_state_s = IDLE;
                end else if (pause) begin
                    next_state_s = PAUSE;
                end else if (step_s && at_end_s && !lp_r) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM output logic: next address, pulse requests and bounds latch.
    always_comb begin
        addr_nxt_s = addr_r;
        done_nxt_s = 1'b0;
        err_nxt_s  = 1'b0;
        latch_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (bounds_ok_s) begin
                        latch_s    = 1'b1;
                        addr_nxt_s = addr_start;
                    end else begin
                        err_nxt_s  = 1'b1;
                    end
                end else begin
                    latch_s = 1'b0;
                end
            end
            RUN, PAUSE: begin
                if (abort) begin
                    done_nxt_s = 1'b1;
                end else if (step_s) begin
                    // addr < hi is guaranteed before the increment, so it
                    // cannot overflow ADDR_W bits.
                    if (!at_end_s) begin
                        addr_nxt_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else if (lp_r) begin
                        addr_nxt_s = lo_r;
                    end else begin
                        done_nxt_s = 1'b1;
                    end
                end else begin
                    addr_nxt_s = addr_r;
                end
            end
            default: begin
                addr_nxt_s = addr_r;
            end
        endcase
    end

    // Output and bounds registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= {ADDR_W{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            lo_r    <= {ADDR_W{1'b0}};
            hi_r    <= {ADDR_W{1'b0}};
            lp_r    <= 1'b0;
        end else begin
            addr_r  <= addr_nxt_s;
            valid_r <= (next_state_s != IDLE);
            busy_r  <= (next_state_s != IDLE);
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            if (latch_s) begin
                lo_r <= addr_start;
                hi_r <= addr_finish;
                lp_r <= loop;
            end else begin
                lo_r <= lo_r;
                hi_r <= hi_r;
                lp_r <= lp_r;
            end
        end
    end

    assign addr       = addr_r;
    assign addr_valid = valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_addr_sequencer
// Directed bench for addr_sequencer (ADDR_W=8, TICK_DIV=4). Inputs change
// and outputs are sampled 1 ns after each rising edge; "cycle c" below means
// the c-th such sample after the edge that accepted start (cycle 0 shows
// the first valid address).
// ---------------------------------------------------------------------------
module tb_addr_sequencer;
    import addr_sequencer_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int TICK_DIV = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] addr_start = 8'd0;
    logic [ADDR_W-1:0] addr_finish = 8'd0;
    logic              start = 1'b0;
    logic              loop = 1'b0;
    logic              pause = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    addr_sequencer #(
        .ADDR_W   (ADDR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_start  (addr_start),
        .addr_finish (addr_finish),
        .start       (start),
        .loop        (loop),
        .pause       (pause),
        .abort       (abort),
        .addr        (addr),
        .addr_valid  (addr_valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] s, input logic [7:0] f, input logic l);
        addr_start  = s;
        addr_finish = f;
        loop        = l;
        start       = 1'b1;
        cyc();
        start       = 1'b0;
    endtask

    // Abort a running playback and check the abort response.
    task automatic abort_and_check(input string name);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_abort done=%b busy=%b valid=%b expected done=1 busy=0 valid=0",
                     name, done, busy, addr_valid);
        end
        cyc();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_abort_pulse done=%b expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checks++;
        if (addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d expected 0", addr); end
        checks++;
        if (addr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", addr_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err); end
    endtask

    task automatic test_oneshot();
        logic [7:0] exp;
        pulse_start(8'd0, 8'd29, 1'b0);
        for (int c = 0; c < 120; c++) begin
            exp = 8'(c / 4);
            checks++;
            if (addr !== exp || addr_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL oneshot c=%0d addr=%0d valid=%b busy=%b done=%b expected addr=%0d valid=1 busy=1 done=0",
                         c, addr, addr_valid, busy, done, exp);
            end
            cyc();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0 || addr !== 8'd29) begin
            errors++;
            $display("FAIL oneshot_end done=%b busy=%b valid=%b addr=%0d expected done=1 busy=0 valid=0 addr=29",
                     done, busy, addr_valid, addr);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_pulse done=%b busy=%b expected done=0 busy=0", done, busy);
        end
    endtask

    task automatic test_loop();
        logic [7:0] exp;
        pulse_start(8'd90, 8'd119, 1'b1);
        for (int c = 0; c < 3 * 120 + 8; c++) begin
            exp = 8'(90 + (c / 4) % 30);
            checks++;
            if (addr !== exp || addr_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL loop c=%0d addr=%0d valid=%b busy=%b done=%b expected addr=%0d valid=1 busy=1 done=0",
                         c, addr, addr_valid, busy, done, exp);
            end
            cyc();
        end
        abort_and_check("loop");
    endtask

    task automatic test_pause();
        pulse_start(8'd30, 8'd59, 1'b0);
        repeat (22) cyc();
        // cycle 22: addr=35, tick=2
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (addr !== 8'd35 || addr_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL pause_hold i=%0d addr=%0d valid=%b busy=%b expected addr=35 valid=1 busy=1",
                         i, addr, addr_valid, busy);
            end
            cyc();
        end
        pause = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (addr !== 8'd35) begin
                errors++;
                $display("FAIL pause_resume i=%0d addr=%0d expected 35", i, addr);
            end
            cyc();
        end
        checks++;
        if (addr !== 8'd36 || addr_valid !== 1'b1) begin
            errors++;
            $display("FAIL pause_next addr=%0d valid=%b expected addr=36 valid=1", addr, addr_valid);
        end
        abort_and_check("pause");
    endtask

    task automatic test_abort();
        pulse_start(8'd60, 8'd89, 1'b0);
        repeat (20) cyc();
        checks++;
        if (addr !== 8'd65) begin
            errors++;
            $display("FAIL abort_pre addr=%0d expected 65", addr);
        end
        abort_and_check("run");
        // abort in IDLE is ignored
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle done=%b busy=%b expected done=0 busy=0", done, busy);
        end
        pulse_start(8'd60, 8'd89, 1'b0);
        checks++;
        if (addr !== 8'd60 || addr_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_replay addr=%0d valid=%b busy=%b expected addr=60 valid=1 busy=1",
                     addr, addr_valid, busy);
        end
        abort_and_check("replay");
    endtask

    task automatic test_err_and_single();
        pulse_start(8'd40, 8'd10, 1'b0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse err=%b busy=%b valid=%b expected err=1 busy=0 valid=0", err, busy, addr_valid);
        end
        cyc();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%b busy=%b expected err=0 busy=0", err, busy);
        end
        pulse_start(8'd50, 8'd50, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (addr !== 8'd50 || addr_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL single c=%0d addr=%0d valid=%b busy=%b done=%b expected addr=50 valid=1 busy=1 done=0",
                         c, addr, addr_valid, busy, done);
            end
            // start on the done-generating edge must be ignored
            if (c == 3) start = 1'b1;
            cyc();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0 || addr !== 8'd50) begin
            errors++;
            $display("FAIL single_end done=%b busy=%b valid=%b addr=%0d expected done=1 busy=0 valid=0 addr=50",
                     done, busy, addr_valid, addr);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back done=%b busy=%b expected done=0 busy=0", done, busy);
        end
    endtask

    task automatic test_bounds_change_and_reset();
        logic [7:0] exp;
        pulse_start(8'd0, 8'd29, 1'b0);
        addr_start  = 8'd60;
        addr_finish = 8'd89;
        for (int c = 0; c < 40; c++) begin
            exp = 8'(c / 4);
            checks++;
            if (addr !== exp || busy !== 1'b1) begin
                errors++;
                $display("FAIL bounds_latched c=%0d addr=%0d busy=%b expected addr=%0d busy=1", c, addr, busy, exp);
            end
            // start while busy must be ignored
            start = (c == 10) ? 1'b1 : 1'b0;
            cyc();
        end
        start = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (addr !== 8'd0 || addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset addr=%0d valid=%b busy=%b done=%b err=%b expected all 0",
                     addr, addr_valid, busy, done, err);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b valid=%b expected 0 0", busy, addr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop();
        test_pause();
        test_abort();
        test_err_and_single();
        test_bounds_change_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
